neuron_mac_unit: RTL and testbench

NEURON_MAC_UNIT -- requirements
Module: neuron_mac_unit

---
 rtl/neuron_mac_unit.sv | 168 ++++++++++++++++
 tb/tb_neuron_mac_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_mac_unit
//  Purpose  : Computes one fixed-point neuron output
//             y = act(sat16((sum_i w[i]*x[i]) >>> FRAC + bias))
//             by streaming N_IN weight/activation pairs out of two
//             synchronous-read BRAMs that share one address.
//  Ports    : clk            rising-edge clock
//             rst_n          synchronous active-low reset
//             start, bias    request and signed bias (latched on accept)
//             w_addr/w_en/w_we/w_do   weight BRAM port (read only)
//             x_addr/x_en/x_do        activation BRAM port (mirrors weight)
//             busy, done, y  status, one-cycle done pulse, held result
//  Revision : 1.0  initial release
// ============================================================================
module neuron_mac_unit #(
    parameter int N_IN = 28,
    parameter int FRAC = 8,
    parameter int RELU = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bias,
    output logic [4:0]  w_addr,
    output logic        w_en,
    output logic        w_we,
    input  logic [15:0] w_do,
    output logic [4:0]  x_addr,
    output logic        x_en,
    input  logic [15:0] x_do,
    output logic        busy,
    output logic        done,
    output logic [15:0] y
);

    localparam logic [4:0]         c_last_addr = 5'(N_IN - 1);
    localparam logic signed [40:0] c_sat_max   = 41'sd32767;
    localparam logic signed [40:0] c_sat_min   = -41'sd32768;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        FINAL = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [4:0]         r_w_addr;
    logic               r_w_en;
    logic               r_rd_vld;   // BRAM outputs hold a pair to accumulate
    logic signed [39:0] r_acc;
    logic [15:0]        r_bias;
    logic [15:0]        r_y;
    logic               r_done;

    logic signed [31:0] w_wd_ext;
    logic signed [31:0] w_xd_ext;
    logic signed [31:0] w_prod;
    logic signed [39:0] w_shifted;
    logic signed [40:0] w_sum;
    logic [15:0]        w_sat;
    logic [15:0]        w_y_next;

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FETCH;
            FETCH:   if (r_w_addr == c_last_addr) w_next = DRAIN;
            DRAIN:   w_next = FINAL;
            FINAL:   w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Both operands sign-extended to 32 bits; the full product of two
    // 16-bit signed values always fits in 32 bits.
    assign w_wd_ext = {{16{w_do[15]}}, w_do};
    assign w_xd_ext = {{16{x_do[15]}}, x_do};
    assign w_prod   = w_wd_ext * w_xd_ext;

    // Arithmetic shift rounds toward -inf; one guard bit on the bias add
    // keeps the sum exact before saturation.
    assign w_shifted = r_acc >>> FRAC;
    assign w_sum     = {w_shifted[39], w_shifted} + {{25{r_bias[15]}}, r_bias};

    always_comb begin
        w_sat = w_sum[15:0];
        if (w_sum > c_sat_max) begin
            w_sat = 16'h7FFF;
        end else if (w_sum < c_sat_min) begin
            w_sat = 16'h8000;
        end
        w_y_next = w_sat;
        if ((RELU != 0) && w_sat[15]) begin
            w_y_next = 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_addr <= 5'd0;
            r_w_en   <= 1'b0;
            r_rd_vld <= 1'b0;
            r_acc    <= 40'sd0;
            r_bias   <= 16'h0000;
            r_y      <= 16'h0000;
            r_done   <= 1'b0;
        end else begin
            r_done   <= (r_state == OUT);
            // A read issued this cycle returns data after this edge.
            r_rd_vld <= r_w_en;
            if (r_rd_vld) begin
                r_acc <= r_acc + {{8{w_prod[31]}}, w_prod};
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bias   <= bias;
                        r_acc    <= 40'sd0;
                        r_w_addr <= 5'd0;
                        r_w_en   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (r_w_addr == c_last_addr) begin
                        r_w_en <= 1'b0;
                    end else begin
                        r_w_addr <= r_w_addr + 5'd1;
                    end
                end
                FINAL: begin
                    r_y <= w_y_next;
                end
                default: ;
            endcase
        end
    end

    assign w_addr = r_w_addr;
    assign x_addr = r_w_addr;
    assign w_en   = r_w_en;
    assign x_en   = r_w_en;
    assign w_we   = 1'b0;
    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign y      = r_y;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_mac_unit
//  Purpose  : Directed, table-driven bench for neuron_mac_unit. Two
//             instances (ReLU on / ReLU off) run in lockstep against a
//             shared BRAM image with synchronous-read models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_neuron_mac_unit;

    localparam int N_IN = 28;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bias;

    logic [4:0]  w_addr_r, x_addr_r, w_addr_l, x_addr_l;
    logic        w_en_r, x_en_r, w_we_r, w_en_l, x_en_l, w_we_l;
    logic [15:0] w_do_r, x_do_r, w_do_l, x_do_l;
    logic        busy_r, done_r, busy_l, done_l;
    logic [15:0] y_r, y_l;

    logic [15:0] wmem [32];
    logic [15:0] xmem [32];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    neuron_mac_unit #(.N_IN(N_IN), .FRAC(8), .RELU(1)) u_dut_relu (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .w_addr(w_addr_r), .w_en(w_en_r), .w_we(w_we_r), .w_do(w_do_r),
        .x_addr(x_addr_r), .x_en(x_en_r), .x_do(x_do_r),
        .busy(busy_r), .done(done_r), .y(y_r)
    );

    neuron_mac_unit #(.N_IN(N_IN), .FRAC(8), .RELU(0)) u_dut_lin (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .w_addr(w_addr_l), .w_en(w_en_l), .w_we(w_we_l), .w_do(w_do_l),
        .x_addr(x_addr_l), .x_en(x_en_l), .x_do(x_do_l),
        .busy(busy_l), .done(done_l), .y(y_l)
    );

    // Synchronous-read BRAM models: data valid one edge after address/enable.
    always @(posedge clk) begin
        if (w_en_r) w_do_r <= wmem[w_addr_r];
        if (x_en_r) x_do_r <= xmem[x_addr_r];
        if (w_en_l) w_do_l <= wmem[w_addr_l];
        if (x_en_l) x_do_l <= xmem[x_addr_l];
    end

    typedef struct {
        logic [15:0] w;
        logic [15:0] x;
        logic [15:0] b;
        bit          ramp;   // x[i] = i instead of a constant
        logic [15:0] y_relu;
        logic [15:0] y_lin;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] w, input logic [15:0] x, input bit ramp);
        for (int i = 0; i < 32; i++) begin
            wmem[i] = w;
            xmem[i] = ramp ? 16'(i) : x;
        end
    endtask

    // Runs one neuron starting at the next edge. With inject set, START is
    // re-asserted (with a different bias) at edges 5 and 30 of the run.
    task automatic run_neuron(input string nm, input logic [15:0] b, input bit inject,
                              input logic [15:0] exp_r, input logic [15:0] exp_l);
        int  lat;
        bit  addr_bad;
        bit  lin_done;
        addr_bad = 1'b0;
        lin_done = 1'b0;
        lat      = 0;
        @(negedge clk);
        start = 1'b1;
        bias  = b;
        @(posedge clk);
        #1;
        if (!(busy_r && w_en_r && w_addr_r == 5'd0)) addr_bad = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            start = inject && (n == 5 || n == 30);
            bias  = start ? 16'h7777 : 16'hAAAA;
            @(posedge clk);
            #1;
            lat = n;
            if (n < N_IN) begin
                if (!(w_en_r && w_addr_r == 5'(n))) addr_bad = 1'b1;
            end else begin
                if (w_en_r || w_addr_r != 5'(N_IN - 1)) addr_bad = 1'b1;
            end
            if (x_addr_r != w_addr_r || x_en_r != w_en_r || w_we_r) addr_bad = 1'b1;
            if (w_addr_l != w_addr_r || w_en_l != w_en_r) addr_bad = 1'b1;
            if (done_l) lin_done = 1'b1;
            if (done_r) break;
        end
        start = 1'b0;
        check({nm, "_latency"}, 32'(lat), 32'(N_IN + 3));
        check({nm, "_addr_seq"}, {31'd0, addr_bad}, 32'd0);
        check({nm, "_lin_done"}, {31'd0, lin_done}, 32'd1);
        check({nm, "_busy_at_done"}, {30'd0, busy_r, busy_l}, 32'd0);
        check({nm, "_y_relu"}, {16'd0, y_r}, {16'd0, exp_r});
        check({nm, "_y_lin"}, {16'd0, y_l}, {16'd0, exp_l});
    endtask

    initial begin
        int  lat;
        bit  saw_done;

        vt[0] = '{16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h1C00, 16'h1C00};
        vt[1] = '{16'hFF00, 16'h0100, 16'h0200, 1'b0, 16'h0000, 16'hE600};
        vt[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF};
        vt[3] = '{16'h8000, 16'h7FFF, 16'h8000, 1'b0, 16'h0000, 16'h8000};
        vt[4] = '{16'h0080, 16'h0080, 16'h0010, 1'b0, 16'h0710, 16'h0710};
        vt[5] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'hFFFF};
        vt[6] = '{16'h0000, 16'h0000, 16'h1234, 1'b0, 16'h1234, 16'h1234};
        vt[7] = '{16'h0100, 16'h0000, 16'h0000, 1'b1, 16'h017A, 16'h017A};

        // Reset with START held high: everything cleared, START ignored.
        rst_n = 1'b0;
        start = 1'b1;
        bias  = 16'h1111;
        load(vt[0].w, vt[0].x, vt[0].ramp);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy_r, done_r, w_en_r, w_addr_r, y_r, busy_l, w_en_l},
              32'd0);
        check("reset_we", {30'd0, w_we_r, w_we_l}, 32'd0);

        // First edge with rst_n high accepts the held START.
        @(negedge clk);
        rst_n = 1'b1;
        bias  = 16'h0000;
        @(posedge clk);
        #1;
        check("start_after_reset_busy", {31'd0, busy_r}, 32'd1);
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            lat = n;
            if (done_r) break;
        end
        check("start_after_reset_latency", 32'(lat), 32'(N_IN + 3));
        check("start_after_reset_y", {16'd0, y_r}, 32'h1C00);

        // Table of directed vectors.
        for (int v = 0; v < 8; v++) begin
            load(vt[v].w, vt[v].x, vt[v].ramp);
            run_neuron($sformatf("vec%0d", v), vt[v].b, 1'b0, vt[v].y_relu, vt[v].y_lin);
        end

        // Reset at edge 10 of a run: aborted, no DONE, Y cleared.
        load(vt[0].w, vt[0].x, 1'b0);
        @(negedge clk);
        start = 1'b1;
        bias  = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_state", {busy_r, w_en_r, done_r, y_r, busy_l, y_l}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done_r || done_l || busy_r) saw_done = 1'b1;
        end
        check("midreset_no_done", {31'd0, saw_done}, 32'd0);
        check("midreset_y_zero", {16'd0, y_r}, 32'd0);
        run_neuron("after_midreset", 16'h0000, 1'b0, 16'h1C00, 16'h1C00);

        // START re-asserted while busy is ignored; then back-to-back run.
        load(vt[1].w, vt[1].x, 1'b0);
        run_neuron("ignored_start", 16'h0200, 1'b1, 16'h0000, 16'hE600);
        load(vt[4].w, vt[4].x, 1'b0);
        run_neuron("back_to_back", 16'h0010, 1'b0, 16'h0710, 16'h0710);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
